// File: rtl/dstack_engine.sv
`default_nettype none
// ============================================================================
//  Module      : dstack_engine
//  Description : Register-based data stack with push/pop1/pop2/hold, rotate
//                and copy of an indexed entry, and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module dstack_engine #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  halt,
    input  logic                  op_valid,
    input  logic [1:0]            movement,
    input  logic                  rotate,
    input  logic                  copy,
    input  logic [5:0]            rotate_addr,
    input  logic [WORD_WIDTH-1:0] next_top,
    input  logic                  clear_flags,
    output logic [WORD_WIDTH-1:0] top,
    output logic [WORD_WIDTH-1:0] second,
    output logic [WORD_WIDTH-1:0] third,
    output logic [WORD_WIDTH-1:0] rotate_value,
    output logic [6:0]            count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int         c_AW      = $clog2(DEPTH);
    localparam logic [6:0] c_DEPTH   = 7'(DEPTH);
    localparam logic [1:0] c_MV_PUSH = 2'b01;
    localparam logic [1:0] c_MV_POP1 = 2'b10;
    localparam logic [1:0] c_MV_POP2 = 2'b11;

    logic [WORD_WIDTH-1:0] r_stack      [DEPTH];
    logic [WORD_WIDTH-1:0] w_stack_next [DEPTH];
    logic [6:0]            r_count;
    logic [6:0]            w_count_next;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic                  w_op;
    logic                  w_addr_ok;
    logic                  w_full;
    logic [6:0]            w_addr_ext;
    logic [WORD_WIDTH-1:0] w_sel;

    assign w_op       = op_valid & ~halt;
    assign w_addr_ext = {1'b0, rotate_addr};
    assign w_full     = (r_count == c_DEPTH);
    // An index is only usable if it names a valid (occupied) entry
    assign w_addr_ok  = (w_addr_ext < r_count) && (w_addr_ext < c_DEPTH);
    assign w_sel      = r_stack[rotate_addr[c_AW-1:0]];

    assign rotate_value = (w_addr_ext < c_DEPTH) ? w_sel : '0;
    assign top          = r_stack[0];
    assign second       = r_stack[1];
    assign third        = r_stack[2];
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_stack_next[i] = r_stack[i];
        end
        w_count_next = r_count;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;

        if (w_op) begin
            if (rotate || copy) begin
                if (!w_addr_ok) begin
                    w_unf_set = 1'b1;
                end else if (rotate) begin
                    w_stack_next[0] = w_sel;
                    for (int i = 1; i < DEPTH; i++) begin
                        if (i <= int'(rotate_addr)) begin
                            w_stack_next[i] = r_stack[i-1];
                        end
                    end
                end else begin
                    w_stack_next[0] = w_sel;
                    for (int i = 1; i < DEPTH; i++) begin
                        w_stack_next[i] = r_stack[i-1];
                    end
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_count_next = r_count + 7'd1;
                    end
                end
            end else begin
                // Every movement, including hold, replaces the top entry
                w_stack_next[0] = next_top;
                case (movement)
                    c_MV_PUSH: begin
                        for (int i = 1; i < DEPTH; i++) begin
                            w_stack_next[i] = r_stack[i-1];
                        end
                        if (w_full) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_count_next = r_count + 7'd1;
                        end
                    end
                    c_MV_POP1: begin
                        for (int i = 1; i < DEPTH - 1; i++) begin
                            w_stack_next[i] = r_stack[i+1];
                        end
                        w_stack_next[DEPTH-1] = '0;
                        w_unf_set    = (r_count < 7'd2);
                        w_count_next = (r_count == 7'd0) ? 7'd0 : r_count - 7'd1;
                    end
                    c_MV_POP2: begin
                        for (int i = 1; i < DEPTH - 2; i++) begin
                            w_stack_next[i] = r_stack[i+2];
                        end
                        w_stack_next[DEPTH-2] = '0;
                        w_stack_next[DEPTH-1] = '0;
                        w_unf_set    = (r_count < 7'd3);
                        w_count_next = (r_count < 7'd2) ? 7'd0 : r_count - 7'd2;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= w_stack_next[i];
            end
            r_count     <= w_count_next;
            // A new error in the same cycle as a clear takes precedence
            r_overflow  <= w_ovf_set | (r_overflow  & ~clear_flags);
            r_underflow <= w_unf_set | (r_underflow & ~clear_flags);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dstack_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dstack_engine
//  Description : Self-checking bench for dstack_engine (DEPTH 16 and DEPTH 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dstack_engine;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         halt = 1'b0;
    logic         op_valid = 1'b0;
    logic [1:0]   movement = 2'b00;
    logic         rotate = 1'b0;
    logic         copy = 1'b0;
    logic [5:0]   rotate_addr = 6'd0;
    logic [W-1:0] next_top = '0;
    logic         clear_flags = 1'b0;

    logic [W-1:0] top_a, second_a, third_a, rv_a;
    logic [6:0]   count_a;
    logic         ovf_a, unf_a;
    logic [W-1:0] top_b, second_b, third_b, rv_b;
    logic [6:0]   count_b;
    logic         ovf_b, unf_b;

    int n_cmp = 0;
    int n_err = 0;

    dstack_engine #(.WORD_WIDTH(W), .DEPTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .halt(halt), .op_valid(op_valid),
        .movement(movement), .rotate(rotate), .copy(copy),
        .rotate_addr(rotate_addr), .next_top(next_top), .clear_flags(clear_flags),
        .top(top_a), .second(second_a), .third(third_a), .rotate_value(rv_a),
        .count(count_a), .overflow(ovf_a), .underflow(unf_a)
    );

    dstack_engine #(.WORD_WIDTH(W), .DEPTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .halt(halt), .op_valid(op_valid),
        .movement(movement), .rotate(rotate), .copy(copy),
        .rotate_addr(rotate_addr), .next_top(next_top), .clear_flags(clear_flags),
        .top(top_b), .second(second_b), .third(third_b), .rotate_value(rv_b),
        .count(count_b), .overflow(ovf_b), .underflow(unf_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           v;
        logic [1:0]   mv;
        bit           rot;
        bit           cp;
        logic [5:0]   a;
        logic [W-1:0] nt;
        bit           clr;
        bit           h;
        logic [W-1:0] et;
        logic [W-1:0] es;
        logic [W-1:0] eth;
        int           ec;
        bit           eo;
        bit           eu;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: front of each queue is the top of stack
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int ca, cb;
    bit oa, ua, ob, ub;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input logic [1:0] mv, input bit rot, input bit cp,
                       input logic [5:0] a, input logic [W-1:0] nt, input bit clr, input bit h);
        op_valid = v; movement = mv; rotate = rot; copy = cp;
        rotate_addr = a; next_top = nt; clear_flags = clr; halt = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drv(0, 2'b00, 0, 0, 6'd0, '0, 0, 0);
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic check_b(input string tag, input logic [W-1:0] et, input logic [W-1:0] es,
                           input logic [W-1:0] eth, input int ec, input bit eo, input bit eu);
        chk({tag, ".top"}, top_b, et);
        chk({tag, ".second"}, second_b, es);
        chk({tag, ".third"}, third_b, eth);
        chk({tag, ".count"}, 32'(count_b), 32'(ec));
        chk({tag, ".overflow"}, 32'(ovf_b), 32'(eo));
        chk({tag, ".underflow"}, 32'(unf_b), 32'(eu));
    endtask

    task automatic push_b(input logic [W-1:0] val);
        drv(1, 2'b01, 0, 0, 6'd0, val, 0, 0);
        tick();
    endtask

    task automatic model_reset();
        qa.delete(); qb.delete();
        for (int i = 0; i < 16; i++) qa.push_back('0);
        for (int i = 0; i < 4; i++) qb.push_back('0);
        ca = 0; cb = 0; oa = 0; ua = 0; ob = 0; ub = 0;
    endtask

    task automatic model_one(input bit b);
        logic [W-1:0] q[$];
        logic [W-1:0] v;
        int c, d, n;
        bit o, u, so, su;
        if (b) begin q = qb; c = cb; o = ob; u = ub; d = 4; end
        else   begin q = qa; c = ca; o = oa; u = ua; d = 16; end
        so = 0; su = 0;
        n = int'(rotate_addr);
        if (op_valid && !halt) begin
            if (rotate || copy) begin
                if (n >= c || n >= d) su = 1;
                else begin
                    v = q[n];
                    if (rotate) q.delete(n);
                    else begin
                        void'(q.pop_back());
                        if (c == d) so = 1; else c++;
                    end
                    q.push_front(v);
                end
            end else begin
                case (movement)
                    2'b00: q[0] = next_top;
                    2'b01: begin
                        void'(q.pop_back());
                        q.push_front(next_top);
                        if (c == d) so = 1; else c++;
                    end
                    2'b10: begin
                        if (c < 2) su = 1;
                        c = (c >= 1) ? c - 1 : 0;
                        q.delete(0); q.delete(0);
                        q.push_front(next_top); q.push_back('0);
                    end
                    default: begin
                        if (c < 3) su = 1;
                        c = (c >= 2) ? c - 2 : 0;
                        q.delete(0); q.delete(0); q.delete(0);
                        q.push_front(next_top); q.push_back('0); q.push_back('0);
                    end
                endcase
            end
        end
        o = clear_flags ? so : (o | so);
        u = clear_flags ? su : (u | su);
        if (b) begin qb = q; cb = c; ob = o; ub = u; end
        else   begin qa = q; ca = c; oa = o; ua = u; end
    endtask

    initial begin
        // ---------------- vector table (DEPTH 16 instance) ----------------
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd1,     0, 0, 32'd1,    32'd0, 32'd0, 1, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd2,     0, 0, 32'd2,    32'd1, 32'd0, 2, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd3,     0, 0, 32'd3,    32'd2, 32'd1, 3, 0, 0});
        tbl.push_back('{1, 2'b10, 0, 0, 6'd0, 32'd5,     0, 0, 32'd5,    32'd1, 32'd0, 2, 0, 0});
        tbl.push_back('{1, 2'b11, 0, 0, 6'd0, 32'd9,     0, 0, 32'd9,    32'd0, 32'd0, 0, 0, 1});
        tbl.push_back('{0, 2'b00, 0, 0, 6'd0, 32'd0,     1, 0, 32'd9,    32'd0, 32'd0, 0, 0, 0});
        tbl.push_back('{1, 2'b00, 0, 0, 6'd0, 32'd7,     0, 0, 32'd7,    32'd0, 32'd0, 0, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd1,     0, 0, 32'd1,    32'd7, 32'd0, 1, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd2,     0, 0, 32'd2,    32'd1, 32'd7, 2, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd3,     0, 0, 32'd3,    32'd2, 32'd1, 3, 0, 0});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'd4,     0, 0, 32'd4,    32'd3, 32'd2, 4, 0, 0});
        tbl.push_back('{1, 2'b00, 1, 0, 6'd2, 32'hDEAD,  0, 0, 32'd2,    32'd4, 32'd3, 4, 0, 0});
        tbl.push_back('{1, 2'b00, 0, 1, 6'd3, 32'hBEEF,  0, 0, 32'd1,    32'd2, 32'd4, 5, 0, 0});
        tbl.push_back('{1, 2'b00, 1, 0, 6'd5, 32'd0,     0, 0, 32'd1,    32'd2, 32'd4, 5, 0, 1});
        tbl.push_back('{1, 2'b00, 0, 1, 6'd4, 32'd0,     0, 0, 32'd1,    32'd1, 32'd2, 6, 0, 1});
        tbl.push_back('{1, 2'b01, 0, 0, 6'd0, 32'hAA,    1, 1, 32'd1,    32'd1, 32'd2, 6, 0, 0});
        tbl.push_back('{1, 2'b00, 1, 0, 6'd0, 32'h77,    0, 0, 32'd1,    32'd1, 32'd2, 6, 0, 0});
        tbl.push_back('{0, 2'b01, 0, 0, 6'd0, 32'h55,    0, 0, 32'd1,    32'd1, 32'd2, 6, 0, 0});
        tbl.push_back('{1, 2'b00, 1, 1, 6'd2, 32'd0,     0, 0, 32'd2,    32'd1, 32'd1, 6, 0, 0});
        tbl.push_back('{1, 2'b11, 0, 0, 6'd0, 32'h10,    0, 0, 32'h10,   32'd4, 32'd3, 4, 0, 0});
        tbl.push_back('{1, 2'b10, 0, 0, 6'd0, 32'h20,    0, 0, 32'h20,   32'd3, 32'd1, 3, 0, 0});

        do_reset();
        chk("reset.top_a", top_a, '0);
        chk("reset.second_a", second_a, '0);
        chk("reset.third_a", third_a, '0);
        chk("reset.count_a", 32'(count_a), 32'd0);
        chk("reset.flags_a", 32'({ovf_a, unf_a}), 32'd0);
        check_b("reset_b", 0, 0, 0, 0, 0, 0);

        foreach (tbl[k]) begin
            drv(tbl[k].v, tbl[k].mv, tbl[k].rot, tbl[k].cp, tbl[k].a, tbl[k].nt, tbl[k].clr, tbl[k].h);
            tick();
            chk($sformatf("vec%0d.top", k), top_a, tbl[k].et);
            chk($sformatf("vec%0d.second", k), second_a, tbl[k].es);
            chk($sformatf("vec%0d.third", k), third_a, tbl[k].eth);
            chk($sformatf("vec%0d.count", k), 32'(count_a), 32'(tbl[k].ec));
            chk($sformatf("vec%0d.overflow", k), 32'(ovf_a), 32'(tbl[k].eo));
            chk($sformatf("vec%0d.underflow", k), 32'(unf_a), 32'(tbl[k].eu));
        end

        // ---------------- DEPTH 4: saturation and overflow ----------------
        do_reset();
        for (int i = 1; i <= 5; i++) push_b(W'(i));
        check_b("sat", 5, 4, 3, 4, 1, 0);
        drv(0, 2'b00, 0, 0, 6'd3, '0, 0, 0);
        #1 chk("sat.bottom", rv_b, 32'd2);
        drv(0, 2'b00, 0, 0, 6'd0, '0, 1, 0);
        tick();
        check_b("sat_clr", 5, 4, 3, 4, 0, 0);

        // ---------------- DEPTH 4: rotate / copy ----------------
        do_reset();
        for (int i = 1; i <= 4; i++) push_b(W'(i));
        check_b("rc_init", 4, 3, 2, 4, 0, 0);
        drv(1, 2'b00, 1, 0, 6'd2, 32'hDEAD, 0, 0);
        tick();
        check_b("rot2", 2, 4, 3, 4, 0, 0);
        drv(1, 2'b00, 0, 1, 6'd3, 32'hBEEF, 0, 0);
        #1 chk("copy3.rv", rv_b, 32'd1);
        tick();
        check_b("copy3", 1, 2, 4, 4, 1, 0);
        drv(1, 2'b00, 1, 0, 6'd5, 32'd0, 0, 0);
        #1 chk("rot5.rv", rv_b, 32'd0);
        tick();
        check_b("rot5", 1, 2, 4, 4, 1, 1);
        // new error in the same cycle as a clear keeps its flag
        drv(1, 2'b00, 1, 0, 6'd5, 32'd0, 1, 0);
        tick();
        check_b("setwins", 1, 2, 4, 4, 0, 1);
        drv(0, 2'b00, 0, 0, 6'd0, '0, 1, 0);
        tick();
        check_b("clr", 1, 2, 4, 4, 0, 0);
        // halt blocks both the operation and the error flag
        drv(1, 2'b00, 1, 0, 6'd5, 32'd0, 0, 1);
        tick();
        check_b("halt_err", 1, 2, 4, 4, 0, 0);

        // ---------------- asynchronous reset mid-cycle ----------------
        do_reset();
        push_b(32'h11);
        push_b(32'h22);
        drv(1, 2'b01, 0, 0, 6'd0, 32'h33, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check_b("async", 0, 0, 0, 0, 0, 0);
        chk("async.top_a", top_a, '0);
        chk("async.count_a", 32'(count_a), 32'd0);
        @(negedge clk);
        drv(0, 2'b00, 0, 0, 6'd0, '0, 0, 0);
        reset_n = 1'b1;
        tick();
        check_b("post_async", 0, 0, 0, 0, 0, 0);
        chk("post_async.count_a", 32'(count_a), 32'd0);

        // ---------------- randomized run against reference model ----------------
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [W-1:0] erv_a, erv_b;
            int r, n;
            r = int'($urandom_range(0, 99));
            drv($urandom_range(0, 99) < 85,
                (r < 40) ? 2'b01 : (r < 60) ? 2'b10 : (r < 75) ? 2'b11 : 2'b00,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 15,
                ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7)),
                W'($urandom),
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 10);
            #1;
            n = int'(rotate_addr);
            erv_a = (n < 16) ? qa[n] : '0;
            erv_b = (n < 4) ? qb[n] : '0;
            chk("rnd.rv_a", rv_a, erv_a);
            chk("rnd.rv_b", rv_b, erv_b);
            model_one(0);
            model_one(1);
            tick();
            chk("rnd.top_a", top_a, qa[0]);
            chk("rnd.second_a", second_a, qa[1]);
            chk("rnd.third_a", third_a, qa[2]);
            chk("rnd.count_a", 32'(count_a), 32'(ca));
            chk("rnd.flags_a", 32'({ovf_a, unf_a}), 32'({oa, ua}));
            chk("rnd.top_b", top_b, qb[0]);
            chk("rnd.second_b", second_b, qb[1]);
            chk("rnd.third_b", third_b, qb[2]);
            chk("rnd.count_b", 32'(count_b), 32'(cb));
            chk("rnd.flags_b", 32'({ovf_b, unf_b}), 32'({ob, ub}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
